// File: rtl/fpga_lut_cfg_ctrl.sv
// Serial configuration loader for an array of 4-input LUTs: collects 16-bit
// truth tables MSB first and writes them one LUT at a time through a one-hot strobe.
module fpga_lut_cfg_ctrl #(
  parameter int NUM_LUTS = 8,
  parameter int IDX_W    = $clog2(NUM_LUTS)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                cfg_bit_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  output logic [15:0]         lut_data_o,
  output logic [NUM_LUTS-1:0] lut_we_o,
  output logic [IDX_W-1:0]    lut_idx_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WRITE,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LUTS - 1);

  state_t           state_q, state_d;
  logic [15:0]      shift_q, shift_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      SHIFT: begin
        // An abort takes priority, so a beat offered alongside it is dropped
        if (abort_i) begin
          state_d = IDLE;
        end else if (cfg_valid_i) begin
          shift_d = {shift_q[14:0], cfg_bit_i};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cfg_ready_o = (state_q == SHIFT);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign lut_data_o  = shift_q;
  assign lut_idx_o   = idx_q;

  // abort_i gates the strobe in its own cycle so an aborted word never lands in a LUT
  always_comb begin
    lut_we_o = '0;
    if (state_q == WRITE && !abort_i) begin
      lut_we_o[idx_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_fpga_lut_cfg_ctrl.sv
// Self-checking bench for fpga_lut_cfg_ctrl: a transaction-level model tracks the
// collected bits as a queue and predicts every cycle's outputs.
module tb_fpga_lut_cfg_ctrl;

  localparam int NUM_LUTS = 2;
  localparam int IDX_W    = 1;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic                start_i;
  logic                abort_i;
  logic                cfg_bit_i;
  logic                cfg_valid_i;
  logic                cfg_ready_o;
  logic [15:0]         lut_data_o;
  logic [NUM_LUTS-1:0] lut_we_o;
  logic [IDX_W-1:0]    lut_idx_o;
  logic                busy_o;
  logic                done_o;

  always #5 clk_i = ~clk_i;

  fpga_lut_cfg_ctrl #(.NUM_LUTS(NUM_LUTS), .IDX_W(IDX_W)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .cfg_bit_i   (cfg_bit_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .lut_data_o  (lut_data_o),
    .lut_we_o    (lut_we_o),
    .lut_idx_o   (lut_idx_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  typedef struct {
    logic                busy;
    logic                ready;
    logic                done;
    logic [NUM_LUTS-1:0] we;
    logic [15:0]         data;
    logic [IDX_W-1:0]    idx;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;

  logic [15:0] words [NUM_LUTS];

  // Reference model: a pass is "in progress", bits pile up in a queue, a full
  // queue means the next cycle is a write, the last write is followed by a done cycle.
  bit m_in_pass, m_write, m_done;
  int m_idx;
  bit m_bits[$];

  function automatic logic [15:0] collected_word(input bit bits[$]);
    logic [15:0] w = '0;
    foreach (bits[i]) w = 16'(w * 2 + bits[i]);
    return w;
  endfunction

  function automatic int count_we(input int bitpos);
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i].we[bitpos] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_done();
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i].done === 1'b1) n++;
    return n;
  endfunction

  // abort_at: -1 none, 0..15 after that many beats of abort_lut, 16 its write cycle, 17 the done cycle
  task automatic run_pass(input int valid_mode, input int abort_lut, input int abort_at,
                          input int start_again_at, input int max_cycles);
    snap_t e, o;
    logic  st, ab, va, bi;
    bit    started = 0;
    int    trailing = 0;
    exp_q.delete();
    obs_q.delete();
    m_in_pass = 0; m_write = 0; m_done = 0; m_idx = 0; m_bits.delete();
    for (int c = 0; c < max_cycles && trailing < 3; c++) begin
      @(negedge clk_i);
      st = (c == 0) || (start_again_at >= 0 && m_in_pass && !m_write && !m_done &&
                        m_idx == 0 && m_bits.size() == start_again_at);
      ab = 1'b0;
      if (abort_at >= 0 && m_in_pass && m_idx == abort_lut) begin
        if (abort_at < 16) ab = !m_write && !m_done && m_bits.size() == abort_at;
        else if (abort_at == 16) ab = m_write;
        else ab = m_done;
      end
      case (valid_mode)
        0:       va = 1'b1;
        1:       va = (c % 2) == 1;
        default: va = $urandom_range(0, 3) != 0;
      endcase
      if (m_in_pass && !m_write && !m_done) bi = words[m_idx][15 - m_bits.size()];
      else bi = 1'($urandom);
      e.busy  = m_in_pass;
      e.ready = m_in_pass && !m_write && !m_done;
      e.done  = m_done;
      e.we    = '0;
      if (m_write && !ab) e.we[m_idx] = 1'b1;
      e.data  = m_write ? collected_word(m_bits) : 'x;
      e.idx   = IDX_W'(m_idx);
      start_i = st; abort_i = ab; cfg_valid_i = va; cfg_bit_i = bi;
      #4;
      o.busy = busy_o; o.ready = cfg_ready_o; o.done = done_o;
      o.we = lut_we_o; o.data = lut_data_o; o.idx = lut_idx_o;
      exp_q.push_back(e);
      obs_q.push_back(o);
      if (!m_in_pass) begin
        if (st && !ab) begin m_in_pass = 1; m_idx = 0; m_bits.delete(); end
      end else if (m_done) begin
        m_done = 0; m_in_pass = 0;
      end else if (ab) begin
        m_in_pass = 0; m_write = 0;
      end else if (m_write) begin
        m_write = 0;
        if (m_idx == NUM_LUTS - 1) m_done = 1;
        else begin m_idx++; m_bits.delete(); end
      end else if (va) begin
        m_bits.push_back(bi);
        if (m_bits.size() == 16) m_write = 1;
      end
      if (st) started = 1;
      if (started && !m_in_pass) trailing++;
    end
    tests_run++;
    if (m_in_pass) begin
      tests_failed++;
      $display("[TB] FAIL pass_timeout: still busy after %0d cycles, required idle", max_cycles);
    end
    @(negedge clk_i);
    start_i = 0; abort_i = 0; cfg_valid_i = 0; cfg_bit_i = 0;
  endtask

  task automatic test_reset();
    reset_i = 1; start_i = 0; abort_i = 0; cfg_valid_i = 0; cfg_bit_i = 0;
    #3;
    tests_run++;
    if ({busy_o, cfg_ready_o, done_o, lut_we_o, lut_idx_o, lut_data_o} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got busy=%b ready=%b done=%b we=%b idx=%0d data=%h, required all 0",
               busy_o, cfg_ready_o, done_o, lut_we_o, lut_idx_o, lut_data_o);
    end
    repeat (2) @(negedge clk_i);
    reset_i = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); #4;
      tests_run++;
      if (busy_o !== 1'b0 || cfg_ready_o !== 1'b0 || lut_we_o !== '0) begin
        tests_failed++;
        $display("[TB] FAIL reset_release_idle: got busy=%b ready=%b we=%b, required 0 0 0",
                 busy_o, cfg_ready_o, lut_we_o);
      end
    end
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk_i);
    start_i = 1; abort_i = 1;
    @(negedge clk_i);
    start_i = 0; abort_i = 0;
    for (int i = 0; i < 3; i++) begin
      #4;
      tests_run++;
      if (busy_o !== 1'b0 || cfg_ready_o !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL start_abort_idle: got busy=%b ready=%b, required 0 0", busy_o, cfg_ready_o);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_full_pass();
    words[0] = 16'h8001; words[1] = 16'h6996;
    run_pass(0, 0, -1, -1, 200);
    for (int c = 0; c < exp_q.size(); c++) begin
      tests_run++;
      if (obs_q[c].busy !== exp_q[c].busy || obs_q[c].ready !== exp_q[c].ready ||
          obs_q[c].done !== exp_q[c].done || obs_q[c].we !== exp_q[c].we ||
          (exp_q[c].busy && obs_q[c].idx !== exp_q[c].idx) ||
          (exp_q[c].we != 0 && obs_q[c].data !== exp_q[c].data)) begin
        tests_failed++;
        $display("[TB] FAIL full_pass cycle %0d: got busy=%b ready=%b done=%b we=%b idx=%0d data=%h, required %b %b %b %b %0d %h",
                 c, obs_q[c].busy, obs_q[c].ready, obs_q[c].done, obs_q[c].we, obs_q[c].idx, obs_q[c].data,
                 exp_q[c].busy, exp_q[c].ready, exp_q[c].done, exp_q[c].we, exp_q[c].idx, exp_q[c].data);
      end
    end
    tests_run++;
    if (obs_q.size() < 37 || obs_q[17].we !== 2'b01 || obs_q[17].data !== 16'h8001 ||
        obs_q[34].we !== 2'b10 || obs_q[34].data !== 16'h6996 || obs_q[35].done !== 1'b1 ||
        obs_q[36].busy !== 1'b0 || count_we(0) != 1 || count_we(1) != 1 || count_done() != 1) begin
      tests_failed++;
      $display("[TB] FAIL full_pass_timeline: got we0=%0d we1=%0d done=%0d pulses, required 1 1 1 at cycles 17/34/35",
               count_we(0), count_we(1), count_done());
    end
  endtask

  task automatic test_backpressure();
    words[0] = 16'h8001; words[1] = 16'h6996;
    run_pass(1, 0, -1, -1, 300);
    for (int c = 0; c < exp_q.size(); c++) begin
      tests_run++;
      if (obs_q[c].busy !== exp_q[c].busy || obs_q[c].ready !== exp_q[c].ready ||
          obs_q[c].done !== exp_q[c].done || obs_q[c].we !== exp_q[c].we ||
          (exp_q[c].busy && obs_q[c].idx !== exp_q[c].idx) ||
          (exp_q[c].we != 0 && obs_q[c].data !== exp_q[c].data)) begin
        tests_failed++;
        $display("[TB] FAIL backpressure cycle %0d: got busy=%b ready=%b done=%b we=%b data=%h, required %b %b %b %b %h",
                 c, obs_q[c].busy, obs_q[c].ready, obs_q[c].done, obs_q[c].we, obs_q[c].data,
                 exp_q[c].busy, exp_q[c].ready, exp_q[c].done, exp_q[c].we, exp_q[c].data);
      end
    end
    tests_run++;
    if (count_we(0) != 1 || count_we(1) != 1 || count_done() != 1) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_counts: got we0=%0d we1=%0d done=%0d, required 1 1 1",
               count_we(0), count_we(1), count_done());
    end
  endtask

  task automatic test_abort_shift();
    words[0] = 16'hA5C3; words[1] = 16'h1234;
    run_pass(0, 1, 10, -1, 200);
    for (int c = 0; c < exp_q.size(); c++) begin
      tests_run++;
      if (obs_q[c].busy !== exp_q[c].busy || obs_q[c].ready !== exp_q[c].ready ||
          obs_q[c].done !== exp_q[c].done || obs_q[c].we !== exp_q[c].we ||
          (exp_q[c].we != 0 && obs_q[c].data !== exp_q[c].data)) begin
        tests_failed++;
        $display("[TB] FAIL abort_shift cycle %0d: got busy=%b ready=%b done=%b we=%b data=%h, required %b %b %b %b %h",
                 c, obs_q[c].busy, obs_q[c].ready, obs_q[c].done, obs_q[c].we, obs_q[c].data,
                 exp_q[c].busy, exp_q[c].ready, exp_q[c].done, exp_q[c].we, exp_q[c].data);
      end
    end
    tests_run++;
    if (count_we(0) != 1 || count_we(1) != 0 || count_done() != 0 ||
        obs_q[obs_q.size()-1].ready !== 1'b0 || obs_q[obs_q.size()-1].busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_shift_counts: got we0=%0d we1=%0d done=%0d, required 1 0 0",
               count_we(0), count_we(1), count_done());
    end
  endtask

  task automatic test_abort_write();
    words[0] = 16'h0F0F; words[1] = 16'hBEEF;
    run_pass(0, 0, 16, -1, 200);
    tests_run++;
    if (count_we(0) != 0 || count_we(1) != 0 || count_done() != 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_write_lut0: got we0=%0d we1=%0d done=%0d, required 0 0 0",
               count_we(0), count_we(1), count_done());
    end
    run_pass(0, 1, 16, -1, 200);
    tests_run++;
    if (count_we(0) != 1 || count_we(1) != 0 || count_done() != 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_write_lut1: got we0=%0d we1=%0d done=%0d, required 1 0 0",
               count_we(0), count_we(1), count_done());
    end
    run_pass(0, 0, -1, -1, 200);
    tests_run++;
    if (obs_q[1].idx !== 1'b0 || obs_q[17].we !== 2'b01 || obs_q[17].data !== 16'h0F0F ||
        count_we(1) != 1 || count_done() != 1) begin
      tests_failed++;
      $display("[TB] FAIL abort_write_restart: got idx=%0d we@17=%b data=%h done=%0d, required 0 01 0f0f 1",
               obs_q[1].idx, obs_q[17].we, obs_q[17].data, count_done());
    end
  endtask

  task automatic test_abort_done();
    words[0] = 16'h1111; words[1] = 16'hF00D;
    run_pass(0, NUM_LUTS - 1, 17, -1, 200);
    tests_run++;
    if (count_done() != 1 || count_we(0) != 1 || count_we(1) != 1 || obs_q[35].done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort_done: got done=%0d we0=%0d we1=%0d, required 1 1 1",
               count_done(), count_we(0), count_we(1));
    end
  endtask

  task automatic test_start_while_busy();
    words[0] = 16'h8001; words[1] = 16'h6996;
    run_pass(0, 0, -1, 5, 200);
    tests_run++;
    if (obs_q[17].we !== 2'b01 || obs_q[17].data !== 16'h8001 || obs_q[34].we !== 2'b10 ||
        obs_q[34].data !== 16'h6996 || count_done() != 1) begin
      tests_failed++;
      $display("[TB] FAIL start_while_busy: got we@17=%b data=%h we@34=%b data=%h done=%0d, required 01 8001 10 6996 1",
               obs_q[17].we, obs_q[17].data, obs_q[34].we, obs_q[34].data, count_done());
    end
  endtask

  task automatic test_reset_mid_pass();
    @(negedge clk_i);
    start_i = 1;
    @(negedge clk_i);
    start_i = 0;
    for (int i = 0; i < 6; i++) begin
      cfg_valid_i = 1; cfg_bit_i = 1'($urandom);
      @(negedge clk_i);
    end
    cfg_valid_i = 1; cfg_bit_i = 1;
    #2 reset_i = 1;
    #1;
    tests_run++;
    if ({busy_o, cfg_ready_o, done_o, lut_we_o, lut_idx_o, lut_data_o} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_pass: got busy=%b ready=%b done=%b we=%b idx=%0d data=%h, required all 0",
               busy_o, cfg_ready_o, done_o, lut_we_o, lut_idx_o, lut_data_o);
    end
    @(negedge clk_i);
    reset_i = 0; cfg_valid_i = 0; cfg_bit_i = 0;
    for (int i = 0; i < 20; i++) begin
      cfg_valid_i = 1'($urandom); cfg_bit_i = 1'($urandom);
      #4;
      tests_run++;
      if (busy_o !== 1'b0 || lut_we_o !== '0 || cfg_ready_o !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_mid_pass_idle: got busy=%b we=%b ready=%b, required 0 0 0",
                 busy_o, lut_we_o, cfg_ready_o);
      end
      @(negedge clk_i);
    end
    cfg_valid_i = 0; cfg_bit_i = 0;
  endtask

  task automatic test_random();
    int alut, aat, sag;
    for (int it = 0; it < 8; it++) begin
      words[0] = 16'($urandom); words[1] = 16'($urandom);
      aat  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 17));
      alut = (aat == 17) ? NUM_LUTS - 1 : int'($urandom_range(0, NUM_LUTS - 1));
      sag  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 15));
      run_pass(2, alut, aat, sag, 400);
      for (int c = 0; c < exp_q.size(); c++) begin
        tests_run++;
        if (obs_q[c].busy !== exp_q[c].busy || obs_q[c].ready !== exp_q[c].ready ||
            obs_q[c].done !== exp_q[c].done || obs_q[c].we !== exp_q[c].we ||
            (exp_q[c].busy && obs_q[c].idx !== exp_q[c].idx) ||
            (exp_q[c].we != 0 && obs_q[c].data !== exp_q[c].data)) begin
          tests_failed++;
          $display("[TB] FAIL random it %0d cycle %0d: got busy=%b ready=%b done=%b we=%b idx=%0d data=%h, required %b %b %b %b %0d %h",
                   it, c, obs_q[c].busy, obs_q[c].ready, obs_q[c].done, obs_q[c].we, obs_q[c].idx, obs_q[c].data,
                   exp_q[c].busy, exp_q[c].ready, exp_q[c].done, exp_q[c].we, exp_q[c].idx, exp_q[c].data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_abort_idle();
    test_full_pass();
    test_backpressure();
    test_abort_shift();
    test_abort_write();
    test_abort_done();
    test_start_while_busy();
    test_reset_mid_pass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
